// File: rtl/vga_bounce_renderer_pkg.sv
// rtl/vga_bounce_renderer_pkg.sv - axis state type and bounce step helper
package vga_bounce_renderer_pkg;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    typedef struct packed {
        dir_e       dir;
        logic [9:0] pos;
    } axis_t;

    // One frame of motion on one axis. Intermediates are 11 bits so that
    // pos+step and lo+step can never wrap for any 10-bit position.
    function automatic axis_t axis_step(input axis_t cur, input logic [10:0] lo,
                                        input logic [10:0] hi, input logic [10:0] step);
        axis_t       nxt;
        logic [10:0] w_pos;
        w_pos = {1'b0, cur.pos};
        nxt   = cur;
        if (cur.dir == DIR_POS) begin
            if (w_pos + step > hi) begin
                nxt.pos = hi[9:0];
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = 10'(w_pos + step);
            end
        end else begin
            if (w_pos < lo + step) begin
                nxt.pos = lo[9:0];
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = 10'(w_pos - step);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_defs.sv
// rtl/vga_timing_defs.sv - visible-window and frame-end constants shared with the timing generator
package vga_timing_defs;

    // Visible window: hCount in [H_VIS_START, H_VIS_END), vCount in [V_VIS_START, V_VIS_END)
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 516;

    // First line after the visible area; (V_FRAME_END, 0) marks end of frame
    localparam int V_FRAME_END = 516;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - rising-edge detector producing a one-clk pulse
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic r_prev;
    logic r_pulse;

    // Previous level resets high so a level already high at reset release never pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= level;
            r_pulse <= level & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/vga_bounce_renderer.sv
// rtl/vga_bounce_renderer.sv - bouncing square sprite over a solid background
module vga_bounce_renderer #(
    parameter int          SIZE      = 32,
    parameter int          STEP      = 2,
    parameter logic [11:0] BG_COLOR  = 12'h00F,
    parameter logic [11:0] SPR_COLOR = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [9:0]  spr_x,
    output logic [9:0]  spr_y
);

    import vga_timing_defs::*;
    import vga_bounce_renderer_pkg::*;

    localparam logic [10:0] X_MIN  = 11'(H_VIS_START);
    localparam logic [10:0] X_MAX  = 11'(H_VIS_END - SIZE);
    localparam logic [10:0] Y_MIN  = 11'(V_VIS_START);
    localparam logic [10:0] Y_MAX  = 11'(V_VIS_END - SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(SIZE);

    localparam axis_t X_RESET = '{dir: DIR_POS, pos: X_MIN[9:0]};
    localparam axis_t Y_RESET = '{dir: DIR_POS, pos: Y_MIN[9:0]};

    axis_t       r_x_axis;
    axis_t       r_y_axis;
    logic [11:0] r_rgb;
    logic        w_frame_end;
    logic        w_tick;
    logic        w_in_x;
    logic        w_in_y;

    assign w_frame_end = (vCount == 10'(V_FRAME_END)) && (hCount == 10'd0);

    frame_tick_gen u_frame_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .level (w_frame_end),
        .pulse (w_tick)
    );

    // Advance both axes once per frame, the clk after the tick, unless paused
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_axis <= X_RESET;
            r_y_axis <= Y_RESET;
        end else if (w_tick && !pause) begin
            r_x_axis <= axis_step(r_x_axis, X_MIN, X_MAX, STEP_W);
            r_y_axis <= axis_step(r_y_axis, Y_MIN, Y_MAX, STEP_W);
        end
    end

    assign spr_x = r_x_axis.pos;
    assign spr_y = r_y_axis.pos;

    assign w_in_x = ({1'b0, hCount} >= {1'b0, spr_x}) && ({1'b0, hCount} < {1'b0, spr_x} + SIZE_W);
    assign w_in_y = ({1'b0, vCount} >= {1'b0, spr_y}) && ({1'b0, vCount} < {1'b0, spr_y} + SIZE_W);

    // Pixel colour: blanking first, then sprite, then background
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= 12'h000;
        end else if (!bright) begin
            r_rgb <= 12'h000;
        end else if (w_in_x && w_in_y) begin
            r_rgb <= SPR_COLOR;
        end else begin
            r_rgb <= BG_COLOR;
        end
    end

    assign rgb        = r_rgb;
    assign frame_tick = w_tick;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb/tb_vga_bounce_renderer.sv - directed self-checking bench for vga_bounce_renderer
module tb_vga_bounce_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        bright;
    logic        pause;
    logic [11:0] rgb;
    logic        frame_tick;
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;
    int t0;

    vga_bounce_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hcount),
        .vCount     (vcount),
        .bright     (bright),
        .pause      (pause),
        .rgb        (rgb),
        .frame_tick (frame_tick),
        .spr_x      (spr_x),
        .spr_y      (spr_y)
    );

    always #5 clk = ~clk;

    // Each negedge with frame_tick high is one clk of pulse
    always @(negedge clk) begin
        if (frame_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Counter model around the frame end: pixel counter advances every 4 clk,
    // so the frame-end condition is held for 4 clk.
    task automatic run_frame();
        hcount = 10'd795;
        vcount = 10'd515;
        for (int s = 0; s < 12; s++) begin
            repeat (4) clk1();
            if (hcount == 10'd799) begin
                hcount = 10'd0;
                vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 10'd1;
            end
        end
        repeat (3) clk1();
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b);
        hcount = h;
        vcount = v;
        bright = b;
        clk1();
    endtask

    initial begin
        rst = 1'b1; hcount = 10'd0; vcount = 10'd0; bright = 1'b0; pause = 1'b0;
        repeat (3) clk1();
        check("reset_spr_x", 32'(spr_x), 32'd144);
        check("reset_spr_y", 32'(spr_y), 32'd35);
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        // Colour selection with sprite at (144,35)
        pix(10'd144, 10'd35, 1'b1); check("rgb_spr_topleft", 32'(rgb), 32'hF00);
        pix(10'd176, 10'd35, 1'b1); check("rgb_right_edge_bg", 32'(rgb), 32'h00F);
        pix(10'd175, 10'd66, 1'b1); check("rgb_spr_botright", 32'(rgb), 32'hF00);
        pix(10'd175, 10'd67, 1'b1); check("rgb_bottom_edge_bg", 32'(rgb), 32'h00F);
        pix(10'd150, 10'd40, 1'b0); check("rgb_blank", 32'(rgb), 32'h000);

        // Reset while the frame-end condition is active, released next clk
        hcount = 10'd0; vcount = 10'd516; bright = 1'b0;
        t0 = tick_cnt;
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        repeat (8) clk1();
        check("rst_mid_cond_ticks", 32'(tick_cnt - t0), 32'd0);
        check("rst_mid_cond_x", 32'(spr_x), 32'd144);

        // First frame
        t0 = tick_cnt;
        run_frame();
        check("frame1_ticks", 32'(tick_cnt - t0), 32'd1);
        check("frame1_x", 32'(spr_x), 32'd146);
        check("frame1_y", 32'(spr_y), 32'd37);

        // Pause across 3 frames
        pause = 1'b1;
        t0 = tick_cnt;
        repeat (3) run_frame();
        pause = 1'b0;
        check("pause_ticks", 32'(tick_cnt - t0), 32'd3);
        check("pause_x", 32'(spr_x), 32'd146);
        check("pause_y", 32'(spr_y), 32'd37);

        // Moved sprite takes effect in pixel comparison
        pix(10'd145, 10'd40, 1'b1); check("rgb_moved_left_bg", 32'(rgb), 32'h00F);
        pix(10'd146, 10'd37, 1'b1); check("rgb_moved_spr", 32'(rgb), 32'hF00);
        pix(10'd146, 10'd36, 1'b1); check("rgb_moved_above_bg", 32'(rgb), 32'h00F);

        // Long run through all four wall hits
        t0 = tick_cnt;
        for (int n = 2; n <= 611; n++) begin
            run_frame();
            case (n)
                224: begin check("f224_x", 32'(spr_x), 32'd592); check("f224_y", 32'(spr_y), 32'd483); end
                225: begin check("f225_x", 32'(spr_x), 32'd594); check("f225_y_clamp", 32'(spr_y), 32'd484); end
                226: begin check("f226_x", 32'(spr_x), 32'd596); check("f226_y_back", 32'(spr_y), 32'd482); end
                304: begin check("f304_x_exact", 32'(spr_x), 32'd752); check("f304_y", 32'(spr_y), 32'd326); end
                305: begin check("f305_x_hold", 32'(spr_x), 32'd752); check("f305_y", 32'(spr_y), 32'd324); end
                306: begin check("f306_x_back", 32'(spr_x), 32'd750); check("f306_y", 32'(spr_y), 32'd322); end
                449: begin check("f449_x", 32'(spr_x), 32'd464); check("f449_y", 32'(spr_y), 32'd36); end
                450: begin check("f450_x", 32'(spr_x), 32'd462); check("f450_y_clamp", 32'(spr_y), 32'd35); end
                451: begin check("f451_x", 32'(spr_x), 32'd460); check("f451_y_back", 32'(spr_y), 32'd37); end
                608: begin check("f608_x", 32'(spr_x), 32'd146); check("f608_y", 32'(spr_y), 32'd351); end
                609: begin check("f609_x_min", 32'(spr_x), 32'd144); check("f609_y", 32'(spr_y), 32'd353); end
                610: begin check("f610_x_hold", 32'(spr_x), 32'd144); check("f610_y", 32'(spr_y), 32'd355); end
                611: begin check("f611_x_back", 32'(spr_x), 32'd146); check("f611_y", 32'(spr_y), 32'd357); end
                default: ;
            endcase
        end
        check("long_run_ticks", 32'(tick_cnt - t0), 32'd610);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
